// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock keypad path: key codes, entry FSM states, BCD limits.
// No logic; constants, types and a time validator only.
// Not applicable (package).
package alarm_clock_pkg;

    localparam logic [3:0] KEY_ENTER      = 4'hA;
    localparam logic [3:0] KEY_CLEAR      = 4'hB;
    localparam logic [3:0] MAX_BCD        = 4'd9;
    localparam logic [3:0] MAX_MS_HR      = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN     = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } entry_state_e;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } alarm_digits_t;

    // HH must be 00..23 and MM 00..59.
    function automatic logic valid_alarm_time(input alarm_digits_t d);
        logic ok;
        ok = (d.ms_hr <= MAX_MS_HR) && (d.ls_hr <= MAX_BCD) &&
             (d.ms_min <= MAX_MS_MIN) && (d.ls_min <= MAX_BCD);
        if (d.ms_hr == MAX_MS_HR && d.ls_hr > MAX_LS_HR_AT_2)
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/entry_timeout_cnt.sv
// Idle-seconds counter for keypad entry; expiring flags the tick that reaches TIMEOUT_SEC.
// expired is expiring registered: high for the one cycle after that edge.
// No backpressure; clear has priority over tick.
module entry_timeout_cnt #(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expiring,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_SEC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expiring = tick && !clear && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= expiring;
            if (clear)
                cnt_q <= '0;
            else if (tick)
                cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_key_entry.sv
// Assembles four keypad BCD digits into HH:MM, validates on ENTER, strobes load_new_a.
// All outputs registered: a key sampled at edge N shows on outputs after edge N.
// No backpressure; keys arrive as single-cycle strobes and are never stalled.
module alarm_key_entry
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_a,
    output logic       entry_active,
    output logic [2:0] digit_count,
    output logic       entry_error,
    output logic       entry_timeout
);

    entry_state_e  state_q, state_d;
    alarm_digits_t dig_q, dig_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          is_digit;
    logic          timeout_now;
    logic          timeout_q;

    assign is_digit = (key_code <= MAX_BCD);

    entry_timeout_cnt #(
        .TIMEOUT_SEC (TIMEOUT_SEC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (key_valid || (state_q == IDLE)),
        .tick     (one_second),
        .expiring (timeout_now),
        .expired  (timeout_q)
    );

    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        // timeout_now can only be set when no key arrives this cycle
        if (timeout_now) begin
            state_d = IDLE;
            dig_d   = '0;
            cnt_d   = 3'd0;
        end else if (key_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        dig_d   = {12'h000, key_code};
                        cnt_d   = 3'd1;
                        state_d = ENTRY;
                    end else if (key_code == KEY_CLEAR) begin
                        dig_d = '0;
                    end
                end
                ENTRY: begin
                    if (is_digit) begin
                        dig_d = {dig_q.ls_hr, dig_q.ms_min, dig_q.ls_min, key_code};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd3)
                            state_d = FULL;
                    end else if (key_code == KEY_ENTER) begin
                        err_d   = 1'b1;
                        dig_d   = '0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end else if (key_code == KEY_CLEAR) begin
                        dig_d   = '0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
                FULL: begin
                    if (key_code == KEY_ENTER) begin
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                        if (valid_alarm_time(dig_q)) begin
                            load_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                            dig_d = '0;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        dig_d   = '0;
                        cnt_d   = 3'd0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dig_d   = '0;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dig_q   <= '0;
            cnt_q   <= 3'd0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    assign new_alarm_ms_hr  = dig_q.ms_hr;
    assign new_alarm_ls_hr  = dig_q.ls_hr;
    assign new_alarm_ms_min = dig_q.ms_min;
    assign new_alarm_ls_min = dig_q.ls_min;
    assign digit_count      = cnt_q;
    assign load_new_a       = load_q;
    assign entry_error      = err_q;
    assign entry_timeout    = timeout_q;
    assign entry_active     = (state_q != IDLE);

endmodule

// File: doc/alarm_key_entry.md
Name: alarm_key_entry

Overview:
Keypad-entry stage directly upstream of the alarm register. It assembles four BCD digits typed on the keypad into an HH:MM alarm time and validates it on ENTER. On success it issues a one-cycle load strobe so the alarm register captures the value. Partial entries are abandoned after an idle timeout counted on the 1 Hz tick from the time generator.

Parameters:
TIMEOUT_SEC, 10, idle seconds in an entry state before the entry is aborted (range 1..255)
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_SEC

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset; low clears all state immediately
one_second  in  1  1-cycle pulse once per second
key_valid  in  1  1-cycle strobe; key_code is valid in this cycle
key_code  in  4  0-9 digit; 4'hA ENTER; 4'hB CLEAR; 4'hC-4'hF ignored
new_alarm_ms_hr  out  4  hours tens digit being entered
new_alarm_ls_hr  out  4  hours units digit
new_alarm_ms_min  out  4  minutes tens digit
new_alarm_ls_min  out  4  minutes units digit
load_new_a  out  1  1-cycle strobe: the four digits are a valid alarm time
entry_active  out  1  high while in ENTRY or FULL
digit_count  out  3  digits entered so far, 0..4
entry_error  out  1  1-cycle pulse: ENTER rejected
entry_timeout  out  1  1-cycle pulse: entry aborted by timeout

Behaviour:
- Reset (reset=0): all digit outputs 4'd0, digit_count 0, load_new_a/entry_error/entry_timeout 0, entry_active 0, state IDLE, timeout counter 0.
- All outputs are registered. A key sampled at edge N takes effect on the outputs after edge N. Pulses are high for exactly the cycle after edge N.
- Digit shift rule: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key. Typing 1,2,3,4 therefore yields 12:34.
- FSM IDLE:
  - A digit key clears the other three digits, loads the key into ls_min, sets count=1 and moves to ENTRY.
  - CLEAR zeroes the digits.
  - ENTER is ignored.
- FSM ENTRY (count 1..3): a digit shifts and increments count. At count 4 the state moves to FULL.
- FSM FULL: further digits are ignored; no shift, no error.
- ENTER in ENTRY (count<4): entry_error pulse, digits zeroed, count 0, go to IDLE.
- ENTER in FULL:
  - The entry is valid if ms_hr<=2, ms_min<=5, ls_hr<=9 and ls_min<=9, and if ms_hr==2 then also ls_hr<=3.
  - Valid: load_new_a pulse, digits retained (held stable at least until the next key), count 0, go to IDLE.
  - Invalid: entry_error pulse, digits zeroed, count 0, go to IDLE.
- CLEAR in ENTRY/FULL: digits zeroed, count 0, go to IDLE, no pulse.
- Timeout:
  - In ENTRY/FULL the counter increments on each one_second.
  - Any key_valid (including ignored codes) clears the counter.
  - When a one_second tick brings the counter to TIMEOUT_SEC: entry_timeout pulse, digits zeroed, count 0, go to IDLE.
  - The counter is held at 0 in IDLE.
- Simultaneous key_valid and one_second: the key is processed and the counter clears; no timeout fires that cycle.
- load_new_a, entry_error and entry_timeout are mutually exclusive.
- Key codes 4'hC-4'hF have no effect other than clearing the timeout counter.
- reset asserted mid-entry aborts the entry with no pulse. Outputs return to reset values without waiting for a clock edge.

Decomposition:
- Shared package alarm_clock_pkg holds:
  - key code constants KEY_ENTER=4'hA and KEY_CLEAR=4'hB
  - FSM state encoding IDLE/ENTRY/FULL
  - BCD limits MAX_MS_HR=2, MAX_LS_HR_AT_2=3, MAX_MS_MIN=5
- One sub-module, entry_timeout_cnt: a CNT_W-bit counter with clear, tick and a registered expired output compared against TIMEOUT_SEC.
- The FSM, shift register and validator stay in the top module.

Test Plan:
- Reset low mid-entry after keys 1,2 -> all outputs 0 immediately; entry_active 0; no pulses.
- Keys 1,2,3,4 then ENTER -> digits 1/2/3/4; digit_count 1,2,3,4; load_new_a high for exactly 1 cycle after the ENTER edge; digits remain 12:34.
- Keys 2,4,0,0 then ENTER -> entry_error pulse, digits 0, no load_new_a. Repeat with 1,9,6,0 -> entry_error. With 2,3,5,9 -> load_new_a.
- Keys 0,7 then ENTER -> entry_error, digit_count 0. Keys 1,2,3,4,5 -> 5 ignored, digits stay 12:34, digit_count 4.
- Key 1, then 10 one_second pulses with no key (TIMEOUT_SEC=10) -> entry_timeout on the 10th tick, digits 0, IDLE. Key on the 9th tick cycle together with one_second -> counter restarts, no timeout.
- Keys 0,8,3,0 then CLEAR then ENTER -> CLEAR zeroes the digits with no pulse; ENTER in IDLE does nothing.
